// File: rtl/multicycle_controller.sv
// Multicycle RV32-subset control FSM: fetch/decode/exec/mem/writeback with memory-wait watchdog.
// Optional macro BRANCH_FULL_EN enables BNE/BLT/BGE/BLTU/BGEU; default build supports BEQ only.
module multicycle_controller #(
  parameter int WAIT_MAX = 15,
  parameter int ALUC_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7_5_i,
  input  logic              zero_i,
  input  logic              lt_i,
  input  logic              ltu_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              sel_addr_o,
  output logic              ir_we_o,
  output logic              pc_we_o,
  output logic              rf_we_o,
  output logic              sel_pc_o,
  output logic [1:0]        sel_alu_src_a_o,
  output logic [1:0]        sel_alu_src_b_o,
  output logic [ALUC_W-1:0] alu_control_o,
  output logic [2:0]        sel_ext_o,
  output logic [1:0]        sel_result_o,
  output logic [2:0]        state_o,
  output logic              illegal_o,
  output logic              bus_err_o
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b1110,
                         ALU_OR  = 4'b0001, ALU_XOR = 4'b0011, ALU_SLL = 4'b0100,
                         ALU_SRL = 4'b0101, ALU_SRA = 4'b1000, ALU_SLT = 4'b0111;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, bus_err_q;

  logic is_r, is_i, is_load, is_store, is_br, is_jal, is_lui;
  logic br_ok, br_taken, legal, timeout;
  logic [3:0] alu_c;

  // funct7_5 only selects SUB for R-type; shift-right uses it for both R and I.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f75, input logic r_type);
    case (f3)
      3'b000:  alu_op = (r_type && f75) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f75 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  assign is_r     = (opcode_i == 7'b0110011);
  assign is_i     = (opcode_i == 7'b0010011);
  assign is_load  = (opcode_i == 7'b0000011);
  assign is_store = (opcode_i == 7'b0100011);
  assign is_br    = (opcode_i == 7'b1100011);
  assign is_jal   = (opcode_i == 7'b1101111);
  assign is_lui   = (opcode_i == 7'b0110111);

`ifdef BRANCH_FULL_EN
  assign br_ok = (funct3_i != 3'b010) && (funct3_i != 3'b011);
  always_comb begin
    case (funct3_i)
      3'b000:  br_taken = zero_i;
      3'b001:  br_taken = ~zero_i;
      3'b100:  br_taken = lt_i;
      3'b101:  br_taken = ~lt_i;
      3'b110:  br_taken = ltu_i;
      3'b111:  br_taken = ~ltu_i;
      default: br_taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = lt_i ^ ltu_i;
  assign br_ok        = (funct3_i == 3'b000);
  assign br_taken     = zero_i;
`endif

  assign legal   = is_r | is_i | is_load | is_store | (is_br & br_ok) | is_jal | is_lui;
  // Watchdog fires on the cycle that would bring the count to WAIT_MAX; a ready that cycle wins.
  assign timeout = (wait_q == 8'(WAIT_MAX - 1)) && !mem_ready_i;
  assign alu_control_o = ALUC_W'(alu_c);
  assign state_o       = state_q;

  always_comb begin
    state_d         = state_q;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    sel_addr_o      = 1'b0;
    ir_we_o         = 1'b0;
    pc_we_o         = 1'b0;
    rf_we_o         = 1'b0;
    sel_pc_o        = 1'b0;
    sel_alu_src_a_o = 2'b00;
    sel_alu_src_b_o = 2'b00;
    alu_c           = ALU_ADD;
    sel_result_o    = 2'b00;
    illegal_o       = illegal_q;
    bus_err_o       = bus_err_q;
    if (is_store)     sel_ext_o = 3'b001;
    else if (is_br)   sel_ext_o = 3'b010;
    else if (is_jal)  sel_ext_o = 3'b011;
    else if (is_lui)  sel_ext_o = 3'b100;
    else              sel_ext_o = 3'b000;

    case (state_q)
      S_FETCH: begin
        mem_req_o       = 1'b1;
        sel_alu_src_a_o = 2'b01;
        sel_alu_src_b_o = 2'b10;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          bus_err_o = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_DECODE: begin
        sel_alu_src_a_o = 2'b10;
        sel_alu_src_b_o = 2'b01;
        if (legal) state_d = S_EXEC;
        else begin
          illegal_o = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_r || is_i) begin
          sel_alu_src_b_o = is_i ? 2'b01 : 2'b00;
          alu_c           = alu_op(funct3_i, funct7_5_i, is_r);
          state_d         = S_WB;
        end else if (is_load || is_store) begin
          sel_alu_src_b_o = 2'b01;
          state_d         = S_MEM;
        end else if (is_br) begin
          alu_c    = ALU_SUB;
          pc_we_o  = br_taken;
          sel_pc_o = br_taken;
        end else if (is_jal) begin
          rf_we_o      = 1'b1;
          sel_result_o = 2'b10;
          pc_we_o      = 1'b1;
          sel_pc_o     = 1'b1;
        end else if (is_lui) begin
          rf_we_o      = 1'b1;
          sel_result_o = 2'b11;
        end
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        sel_addr_o = 1'b1;
        mem_we_o   = is_store;
        if (mem_ready_i) state_d = is_load ? S_WB : S_FETCH;
        else if (timeout) begin
          bus_err_o = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_WB: begin
        rf_we_o      = 1'b1;
        sel_result_o = is_load ? 2'b01 : 2'b00;
        state_d      = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    if (state_d != state_q || mem_ready_i) wait_d = 8'd0;
    else if (state_q == S_FETCH || state_q == S_MEM) wait_d = wait_q + 8'd1;
    else wait_d = wait_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_o;
      bus_err_q <= bus_err_o;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words queued with stimulus.
module tb_multicycle_controller;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, sel_addr, ir_we, pc_we, rf_we, sel_pc, illegal, bus_err;
  logic [1:0] src_a, src_b, sel_result;
  logic [3:0] alu_control;
  logic [2:0] sel_ext, state;

  int   n_chk = 0, n_pass = 0, cyc_idx = 0;
  string tname = "init";
  logic [2:0] cur_ext = 3'b000;
  logic [24:0] exp_q[$];

  localparam logic [3:0] ADD = 4'b0010;

  multicycle_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .funct3_i(funct3), .funct7_5_i(funct7_5),
    .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .sel_addr_o(sel_addr), .ir_we_o(ir_we),
    .pc_we_o(pc_we), .rf_we_o(rf_we), .sel_pc_o(sel_pc), .sel_alu_src_a_o(src_a),
    .sel_alu_src_b_o(src_b), .alu_control_o(alu_control), .sel_ext_o(sel_ext),
    .sel_result_o(sel_result), .state_o(state), .illegal_o(illegal), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [24:0] mk(input logic [2:0] st, input logic pcw, irw, rfw, mw,
                                     input logic req, addr, spc, input logic [1:0] a, b,
                                     input logic [3:0] alu, input logic [1:0] res,
                                     input logic ill, be);
    return {st, pcw, irw, rfw, mw, req, addr, spc, a, b, alu, cur_ext, res, ill, be};
  endfunction

  function automatic logic [24:0] e_fetch(input logic rdy);
    return mk(3'd0, rdy, rdy, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, ADD, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_dec(input logic ill);
    return mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, ADD, 2'b00, ill, 1'b0);
  endfunction
  function automatic logic [24:0] e_exec(input logic pcw, rfw, spc, input logic [1:0] b,
                                         input logic [3:0] alu, input logic [1:0] res);
    return mk(3'd2, pcw, 1'b0, rfw, 1'b0, 1'b0, 1'b0, spc, 2'b00, b, alu, res, 1'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_mem(input logic mw, be);
    return mk(3'd3, 1'b0, 1'b0, 1'b0, mw, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, ADD, 2'b00, 1'b0, be);
  endfunction
  function automatic logic [24:0] e_wb(input logic [1:0] res);
    return mk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, ADD, res, 1'b0, 1'b0);
  endfunction
  function automatic logic [24:0] e_trap(input logic ill, be);
    return mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, ADD, 2'b00, ill, be);
  endfunction

  function automatic logic [24:0] observed();
    return {state, pc_we, ir_we, rf_we, mem_we, mem_req, sel_addr, sel_pc, src_a, src_b,
            alu_control, sel_ext, sel_result, illegal, bus_err};
  endfunction

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic cyc(input logic mr, input logic z, input logic [24:0] e);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(e);
    @(negedge clk);
    check($sformatf("%s[%0d]", tname, cyc_idx), {7'd0, observed()}, {7'd0, exp_q.pop_front()});
    cyc_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, input logic [2:0] ext);
    tname = nm; cyc_idx = 0;
    opcode = op; funct3 = f3; funct7_5 = f75; cur_ext = ext;
  endtask

  task automatic fd(input string nm, input logic [6:0] op, input logic [2:0] f3,
                    input logic f75, input logic [2:0] ext);
    start(nm, op, f3, f75, ext);
    cyc(1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b1, 1'b0, e_dec(1'b0));
  endtask

  task automatic do_reset(input string nm);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check({nm, "_async"}, {7'd0, observed()}, {7'd0, e_fetch(1'b0)});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {7'd0, observed()}, {7'd0, e_fetch(1'b0)});
    rst_n = 1'b1;

    fd("add", 7'b0110011, 3'b000, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b00, 4'b0010, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    fd("sub", 7'b0110011, 3'b000, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    fd("slt", 7'b0110011, 3'b010, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b00, 4'b0111, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    fd("and", 7'b0110011, 3'b111, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b00, 4'b1110, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    fd("addi_f75", 7'b0010011, 3'b000, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b01, 4'b0010, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    fd("srai", 7'b0010011, 3'b101, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b01, 4'b1000, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    fd("xori", 7'b0010011, 3'b100, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b01, 4'b0011, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    start("lw_stall", 7'b0000011, 3'b010, 1'b0, 3'b000);
    cyc(1'b0, 1'b0, e_fetch(1'b0));
    cyc(1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b1, 1'b0, e_dec(1'b0));
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b01, ADD, 2'b00));
    repeat (3) cyc(1'b0, 1'b0, e_mem(1'b0, 1'b0));
    cyc(1'b1, 1'b0, e_mem(1'b0, 1'b0));
    cyc(1'b1, 1'b0, e_wb(2'b01));

    fd("beq_t", 7'b1100011, 3'b000, 1'b0, 3'b010);
    cyc(1'b1, 1'b1, e_exec(1'b1, 1'b0, 1'b1, 2'b00, 4'b0110, 2'b00));
    fd("beq_nt", 7'b1100011, 3'b000, 1'b0, 3'b010);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 2'b00));

    fd("jal", 7'b1101111, 3'b000, 1'b0, 3'b011);
    cyc(1'b1, 1'b0, e_exec(1'b1, 1'b1, 1'b1, 2'b00, ADD, 2'b10));
    fd("lui", 7'b0110111, 3'b000, 1'b0, 3'b100);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b1, 1'b0, 2'b00, ADD, 2'b11));

    // Ready on the very cycle the watchdog would fire is a success.
    fd("sw_edge", 7'b0100011, 3'b010, 1'b0, 3'b001);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b01, ADD, 2'b00));
    repeat (14) cyc(1'b0, 1'b0, e_mem(1'b1, 1'b0));
    cyc(1'b1, 1'b0, e_mem(1'b1, 1'b0));

`ifdef BRANCH_FULL_EN
    fd("bne_t", 7'b1100011, 3'b001, 1'b0, 3'b010);
    cyc(1'b1, 1'b0, e_exec(1'b1, 1'b0, 1'b1, 2'b00, 4'b0110, 2'b00));
    fd("bne_nt", 7'b1100011, 3'b001, 1'b0, 3'b010);
    cyc(1'b1, 1'b1, e_exec(1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 2'b00));
`else
    start("bne_ill", 7'b1100011, 3'b001, 1'b0, 3'b010);
    cyc(1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b1, 1'b0, e_dec(1'b1));
    repeat (2) cyc(1'b1, 1'b0, e_trap(1'b1, 1'b0));
    do_reset("rst_bne");
`endif

    start("blt_bad", 7'b1100011, 3'b010, 1'b0, 3'b010);
    cyc(1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b1, 1'b0, e_dec(1'b1));
    repeat (3) cyc(1'b1, 1'b0, e_trap(1'b1, 1'b0));
    do_reset("rst_ill");

    start("bad_op", 7'b1111111, 3'b000, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b1, 1'b0, e_dec(1'b1));
    cyc(1'b0, 1'b0, e_trap(1'b1, 1'b0));
    do_reset("rst_op");

    fd("lw_rst", 7'b0000011, 3'b010, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b01, ADD, 2'b00));
    cyc(1'b0, 1'b0, e_mem(1'b0, 1'b0));
    do_reset("rst_mem");
    cyc(1'b0, 1'b0, e_fetch(1'b0));

    fd("sw_to", 7'b0100011, 3'b010, 1'b0, 3'b001);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b01, ADD, 2'b00));
    repeat (14) cyc(1'b0, 1'b0, e_mem(1'b1, 1'b0));
    cyc(1'b0, 1'b0, e_mem(1'b1, 1'b1));
    repeat (3) cyc(1'b1, 1'b0, e_trap(1'b0, 1'b1));
    do_reset("rst_bus");
    fd("after_bus", 7'b0110011, 3'b110, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, e_exec(1'b0, 1'b0, 1'b0, 2'b00, 4'b0001, 2'b00));
    cyc(1'b1, 1'b0, e_wb(2'b00));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum consecutive memory wait cycles before a bus error; legal range 1..255.
REQ-002 Parameter ALUC_W, default 4: width of alu_control.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  7  from instruction register; funct3 input 3; funct7_5 input 1.
REQ-006 zero, lt, ltu  input  1 each  ALU flags, sampled in EXEC only.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 mem_req  output  1; mem_we  output  1; sel_addr  output  1 (0 = PC, 1 = ALUOut).
REQ-009 ir_we, pc_we, rf_we  output  1 each; sel_pc  output  1 (0 = ALU result, 1 = ALUOut).
REQ-010 sel_alu_src_a  output  2 (00 = rs1, 01 = PC, 10 = oldPC); sel_alu_src_b  output  2 (00 = rs2, 01 = imm, 10 = const 4).
REQ-011 alu_control  output  ALUC_W; sel_ext  output  3; sel_result  output  2 (00 = ALUOut, 01 = mem data, 10 = PC, 11 = imm).
REQ-012 state  output  3; illegal  output  1; bus_err  output  1.

Function
REQ-013 The FSM SHALL have states FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5, with a registered next-state and all other outputs decoded combinationally from state and inputs.
REQ-014 In FETCH: mem_req = 1 and sel_addr = 0; when mem_ready = 1, ir_we = 1 and pc_we = 1 (src_a = PC, src_b = 4, ADD, sel_pc = 0), then go to DECODE; otherwise hold.
REQ-015 In DECODE: src_a = oldPC, src_b = imm, ADD, sel_ext per opcode; opcodes R 0110011, I 0010011, Load 0000011, Store 0100011, Branch 1100011, JAL 1101111 and LUI 0110111 go to EXEC; all others go to TRAP with illegal = 1.
REQ-016 EXEC for R-type/I-type: ALU operation from funct3/funct7_5 (ADD 0010, SUB 0110, AND 1110, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 1000, SLT 0111; funct7_5 is ignored for I-type except shift-right), then go to WB.
REQ-017 EXEC for Load/Store: rs1 + imm (ADD), then go to MEM.
REQ-018 EXEC for Branch: SUB of rs1 - rs2; if taken, pc_we = 1 and sel_pc = 1; then go to FETCH.
REQ-019 EXEC for JAL: rf_we = 1, sel_result = 10, pc_we = 1, sel_pc = 1, then go to FETCH; for LUI: rf_we = 1, sel_result = 11, then go to FETCH.
REQ-020 In MEM: mem_req = 1 and sel_addr = 1, with mem_we = 1 for Store; on mem_ready a Store goes to FETCH and a Load goes to WB.
REQ-021 In WB: rf_we = 1, sel_result = 01 for Load and 00 otherwise, then go to FETCH.
REQ-022 An 8-bit wait counter SHALL clear on every state change and on mem_ready, and increment on each FETCH/MEM cycle while mem_ready = 0.
REQ-023 If the wait counter reaches WAIT_MAX with mem_ready still 0, the FSM goes to TRAP with bus_err = 1.
REQ-024 mem_ready arriving in the same cycle the counter reaches WAIT_MAX SHALL count as success, with no trap.
REQ-025 TRAP SHALL be absorbing: all write enables and mem_req = 0, and illegal/bus_err hold their values until reset.
REQ-026 Write enables (pc_we, ir_we, rf_we, mem_we) SHALL each be asserted for exactly one cycle per instruction, except in stall cycles.

Reset
REQ-027 On rst_n = 0, asynchronously: state = FETCH, wait counter = 0, illegal = 0, bus_err = 0.
REQ-028 Reset asserted mid-instruction SHALL abandon the instruction; the first edge after deassertion is a FETCH cycle.

Configuration
REQ-029 Macro BRANCH_FULL_EN.
REQ-030 Without BRANCH_FULL_EN: only BEQ (funct3 000, taken when zero = 1) is supported, and any other branch funct3 goes to TRAP with illegal = 1 in DECODE.
REQ-031 With BRANCH_FULL_EN, branch conditions SHALL be:
- BEQ: taken when zero = 1
- BNE: taken when zero = 0
- BLT: taken when lt = 1
- BGE: taken when lt = 0
- BLTU: taken when ltu = 1
- BGEU: taken when ltu = 0
- funct3 010/011: go to TRAP with illegal = 1 in DECODE

Verification
REQ-032 ADD (0110011, funct3 000, funct7_5 0), mem_ready held at 1 -> states 0,1,2,4,0; alu_control = 0010 in EXEC; rf_we only in WB.
REQ-033 LW with mem_ready low for 3 MEM cycles -> MEM held 4 cycles; sel_result = 01 in WB; bus_err = 0.
REQ-034 SW with mem_ready never asserted in MEM (WAIT_MAX = 15) -> TRAP after 15 MEM cycles; bus_err = 1; no mem_we after trap.
REQ-035 BEQ with zero = 1 -> pc_we = 1 and sel_pc = 1 in EXEC; BEQ with zero = 0 -> pc_we = 0 in EXEC.
REQ-036 BNE (funct3 001) -> TRAP with illegal = 1 without BRANCH_FULL_EN; taken when zero = 0 with it.
REQ-037 rst_n pulsed low during MEM of a load -> state = 0 immediately; no rf_we issued.
